// File: rtl/tlb_lru_ctrl.sv
// LRU replacement controller for a set-associative TLB: per-set/per-way age counters,
// touch updates with one-cycle renormalisation on saturation, sequential flush, victim query.
module tlb_lru_ctrl #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 16,
   parameter int LRU_BITS = 4,
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int SET_W    = $clog2(NUM_SETS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                touch_valid,
   output logic                touch_ready,
   input  logic [SET_W-1:0]    touch_set,
   input  logic [WAY_W-1:0]    touch_way,
   input  logic                vic_req,
   output logic                vic_ready,
   input  logic [SET_W-1:0]    vic_set,
   input  logic [NUM_WAYS-1:0] vic_way_valid,
   output logic                vic_valid,
   output logic [WAY_W-1:0]    vic_way,
   input  logic                flush,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, RENORM, FLUSH} state_e;

   localparam logic [LRU_BITS-1:0] CNT_MAX = '1;

   state_e                                         state_q;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0][LRU_BITS-1:0] cnt_q;
   logic [SET_W-1:0]                               rn_set_q;
   logic [WAY_W-1:0]                               rn_way_q;
   logic [SET_W-1:0]                               fl_idx_q;
   logic                                           vic_valid_q;
   logic [WAY_W-1:0]                               vic_way_q;

   logic [LRU_BITS-1:0]                  tmax_d;
   logic [NUM_WAYS-1:0][LRU_BITS-1:0]    rank_d;
   logic [WAY_W-1:0]                     vic_sel_d;
   logic [LRU_BITS-1:0]                  vmin_d;
   logic                                 found_d;

   assign busy        = (state_q != IDLE);
   assign vic_ready   = !busy;
   assign touch_ready = (state_q == IDLE) && !flush;
   assign vic_valid   = vic_valid_q;
   assign vic_way     = vic_way_q;

   always_comb begin
      tmax_d = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (cnt_q[touch_set][w] > tmax_d) tmax_d = cnt_q[touch_set][w];
   end

   // Rank = number of ways strictly older, with index breaking ties so ranks are unique.
   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         rank_d[w] = '0;
         for (int v = 0; v < NUM_WAYS; v++)
            if ((cnt_q[rn_set_q][v] < cnt_q[rn_set_q][w]) ||
                ((cnt_q[rn_set_q][v] == cnt_q[rn_set_q][w]) && (v < w)))
               rank_d[w] = rank_d[w] + LRU_BITS'(1);
      end
   end

   always_comb begin
      vic_sel_d = '0;
      found_d   = 1'b0;
      vmin_d    = cnt_q[vic_set][0];
      for (int w = 0; w < NUM_WAYS; w++)
         if (!found_d && !vic_way_valid[w]) begin
            vic_sel_d = WAY_W'(w);
            found_d   = 1'b1;
         end
      if (!found_d)
         for (int w = 1; w < NUM_WAYS; w++)
            if (cnt_q[vic_set][w] < vmin_d) begin
               vmin_d    = cnt_q[vic_set][w];
               vic_sel_d = WAY_W'(w);
            end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rn_set_q    <= '0;
         rn_way_q    <= '0;
         fl_idx_q    <= '0;
         vic_valid_q <= 1'b0;
         vic_way_q   <= '0;
      end else begin
         // Query reads the counters as they stand this cycle, before any touch lands.
         vic_valid_q <= vic_req && vic_ready;
         if (vic_req && vic_ready) vic_way_q <= vic_sel_d;
         case (state_q)
            IDLE: begin
               if (flush) begin
                  state_q  <= FLUSH;
                  fl_idx_q <= '0;
               end else if (touch_valid) begin
                  if (tmax_d == CNT_MAX) begin
                     state_q  <= RENORM;
                     rn_set_q <= touch_set;
                     rn_way_q <= touch_way;
                  end else begin
                     cnt_q[touch_set][touch_way] <= tmax_d + LRU_BITS'(1);
                  end
               end
            end
            RENORM: begin
               for (int w = 0; w < NUM_WAYS; w++)
                  cnt_q[rn_set_q][w] <= (WAY_W'(w) == rn_way_q) ? LRU_BITS'(NUM_WAYS) : rank_d[w];
               if (flush) begin
                  state_q  <= FLUSH;
                  fl_idx_q <= '0;
               end else begin
                  state_q  <= IDLE;
               end
            end
            FLUSH: begin
               cnt_q[fl_idx_q] <= '0;
               fl_idx_q        <= fl_idx_q + SET_W'(1);
               if (fl_idx_q == SET_W'(NUM_SETS - 1)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_lru_ctrl.sv
// Directed bench for tlb_lru_ctrl: reference counter model feeds an expected-victim queue
// that a negedge monitor drains when vic_valid pulses.
module tb_tlb_lru_ctrl;
   localparam int NW = 4;
   localparam int NS = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          touch_valid = 1'b0;
   logic          touch_ready;
   logic [3:0]    touch_set = '0;
   logic [1:0]    touch_way = '0;
   logic          vic_req = 1'b0;
   logic          vic_ready;
   logic [3:0]    vic_set = '0;
   logic [NW-1:0] vic_way_valid = '0;
   logic          vic_valid;
   logic [1:0]    vic_way;
   logic          flush = 1'b0;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int mdl[NS][NW];

   tlb_lru_ctrl dut (
      .clk(clk), .rst(rst),
      .touch_valid(touch_valid), .touch_ready(touch_ready),
      .touch_set(touch_set), .touch_way(touch_way),
      .vic_req(vic_req), .vic_ready(vic_ready), .vic_set(vic_set),
      .vic_way_valid(vic_way_valid), .vic_valid(vic_valid), .vic_way(vic_way),
      .flush(flush), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && vic_valid) begin
         if (exp_q.size() == 0) chk("vic_unexpected", 1, 0);
         else chk("vic_way", vic_way, exp_q.pop_front());
      end
   end

   function automatic void mclear();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) mdl[s][w] = 0;
   endfunction

   function automatic int mvic(int s, logic [NW-1:0] v);
      int m;
      for (int w = 0; w < NW; w++) if (!v[w]) return w;
      m = 0;
      for (int w = 1; w < NW; w++) if (mdl[s][w] < mdl[s][m]) m = w;
      return m;
   endfunction

   function automatic bit mtouch(int s, int w);
      int mx;
      int rk[NW];
      mx = 0;
      for (int i = 0; i < NW; i++) if (mdl[s][i] > mx) mx = mdl[s][i];
      if (mx < 15) begin
         mdl[s][w] = mx + 1;
         return 1'b0;
      end
      for (int i = 0; i < NW; i++) begin
         rk[i] = 0;
         for (int j = 0; j < NW; j++)
            if (mdl[s][j] < mdl[s][i] || (mdl[s][j] == mdl[s][i] && j < i)) rk[i]++;
      end
      for (int i = 0; i < NW; i++) mdl[s][i] = rk[i];
      mdl[s][w] = NW;
      return 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic touch(input int s, input int w);
      bit rn;
      chk("touch_ready_pre", touch_ready, 1);
      touch_valid = 1'b1; touch_set = 4'(s); touch_way = 2'(w);
      rn = mtouch(s, w);
      tick();
      touch_valid = 1'b0;
      if (rn) begin
         chk("renorm_touch_ready", touch_ready, 0);
         chk("renorm_busy", busy, 1);
         chk("renorm_vic_ready", vic_ready, 0);
         tick();
      end
   endtask

   task automatic query(input int s, input logic [NW-1:0] v);
      chk("vic_ready_pre", vic_ready, 1);
      vic_req = 1'b1; vic_set = 4'(s); vic_way_valid = v;
      exp_q.push_back(mvic(s, v));
      tick();
      vic_req = 1'b0;
      chk("vic_valid_pulse", vic_valid, 1);
   endtask

   // Walk the 16 flush cycles with a stray query and a repeat flush that must be ignored.
   task automatic flush_body();
      for (int i = 0; i < NS; i++) begin
         chk("flush_busy", busy, 1);
         chk("flush_vic_ready", vic_ready, 0);
         chk("flush_touch_ready", touch_ready, 0);
         vic_req = 1'b1; vic_set = 4'd7; vic_way_valid = '1;
         flush = (i == 6);
         tick();
      end
      vic_req = 1'b0; flush = 1'b0;
      chk("flush_done_busy", busy, 0);
      chk("flush_done_touch_ready", touch_ready, 1);
      mclear();
   endtask

   initial begin
      mclear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_touch_ready", touch_ready, 1);
      chk("rst_vic_ready", vic_ready, 1);
      chk("rst_vic_valid", vic_valid, 0);
      chk("rst_vic_way", vic_way, 0);
      query(3, 4'b1111);
      tick();
      chk("vic_valid_one_cycle", vic_valid, 0);

      // in-order touches, then invalid-first selection
      for (int w = 0; w < NW; w++) touch(2, w);
      query(2, 4'b1111);
      query(2, 4'b1011);
      touch(2, 3);
      query(2, 4'b1111);
      query(2, 4'b1110);

      // saturation -> renorm to {0,4,1,2}
      for (int i = 0; i < 13; i++) touch(5, 2);
      touch(5, 3);
      touch(5, 1);
      touch(5, 1);
      chk("renorm_model_w1", mdl[5][1], 4);
      query(5, 4'b1111);
      query(5, 4'b1110);
      query(5, 4'b1101);

      // flush with set 7 populated; touch in the flush cycle is refused
      touch(7, 0); touch(7, 1); touch(7, 2);
      flush = 1'b1; touch_valid = 1'b1; touch_set = 4'd7; touch_way = 2'd2;
      #1 chk("flush_cycle_touch_ready", touch_ready, 0);
      tick();
      flush = 1'b0; touch_valid = 1'b0;
      flush_body();
      query(7, 4'b1111);
      query(2, 4'b1111);

      // same-cycle touch and query see pre-touch counters
      touch(1, 1); touch(1, 0); touch(1, 2);
      vic_req = 1'b1; vic_set = 4'd1; vic_way_valid = 4'b1111;
      touch_valid = 1'b1; touch_set = 4'd1; touch_way = 2'd0;
      exp_q.push_back(mvic(1, 4'b1111));
      void'(mtouch(1, 0));
      tick();
      vic_req = 1'b0; touch_valid = 1'b0;
      query(1, 4'b1111);
      query(1, 4'b1101);

      // flush arriving during renorm is honoured after it
      for (int i = 0; i < 15; i++) touch(9, 0);
      touch_valid = 1'b1; touch_set = 4'd9; touch_way = 2'd0;
      void'(mtouch(9, 0));
      tick();
      touch_valid = 1'b0; flush = 1'b1;
      chk("rn_flush_busy", busy, 1);
      tick();
      flush = 1'b0;
      flush_body();
      query(9, 4'b1111);

      // reset in the middle of a flush
      touch(10, 3); touch(10, 2); touch(10, 1); touch(10, 0);
      query(10, 4'b1111);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      chk("midflush_busy", busy, 1);
      rst = 1'b1;
      #1 chk("rst_async_busy", busy, 0);
      chk("rst_async_vic_valid", vic_valid, 0);
      mclear();
      tick();
      chk("rst_edge_vic_valid", vic_valid, 0);
      rst = 1'b0;
      query(10, 4'b1111);
      query(2, 4'b1111);

      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
